// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST pattern generator.
// Holds the FSM state encoding, the index width and the Fibonacci LFSR next-state function.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IDX_W = 16;

  // Generic up-to-32-bit step: shift left, feed the tap parity into bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                            input logic [31:0] poly,
                                            input int          w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return {s[30:0], ^(s & poly & mask)} & mask;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR state register with parallel load and single-step advance.
// Load has priority over step; INIT is the value taken on reset.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int               WIDTH = 2,
  parameter logic [WIDTH-1:0] POLY  = 2'b11,
  parameter logic [WIDTH-1:0] INIT  = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
    end else if (load) begin
      r_state <= load_val;
    end else if (step) begin
      r_state <= WIDTH'(lfsr_next(32'(r_state), 32'(POLY), WIDTH));
    end
  end

  assign q = r_state;

endmodule

// File: rtl/bist_pattern_gen.sv
// LFSR pattern source: NUM_PATTERNS vectors over valid/ready, then done.
// Define BIST_ZERO_PAD_EN to make vector 0 of every run all-zeros.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 2,
  parameter logic [WIDTH-1:0] POLY         = 2'b11,
  parameter logic [WIDTH-1:0] SEED         = 2'b01,
  parameter int               NUM_PATTERNS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [WIDTH-1:0] pat_data,
  output logic [IDX_W-1:0] pat_index,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
`ifdef BIST_ZERO_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_seed;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_index;
  logic             r_busy;
  logic             r_done;

  logic             w_idle;
  logic [WIDTH-1:0] w_seed_in_fix;
  logic [WIDTH-1:0] w_seed_use;
  logic             w_start;
  logic             w_xfer;
  logic             w_last;
  logic             w_pad_slot;
  logic             w_lfsr_step;
  logic [WIDTH-1:0] w_lfsr_q;
  logic [WIDTH-1:0] w_lfsr_next;

  assign w_idle        = (r_state != RUN);
  assign w_seed_in_fix = (seed_in == '0) ? WIDTH'(1) : seed_in;
  // A seed loaded in the same cycle as start applies to that run.
  assign w_seed_use    = (seed_load && w_idle) ? w_seed_in_fix : r_seed;
  assign w_start       = start && w_idle;
  assign w_xfer        = (r_state == RUN) && r_valid && pat_ready;
  assign w_last        = (r_index == LAST_IDX);
  assign w_pad_slot    = PAD_EN && (r_index == '0);
  assign w_lfsr_step   = w_xfer && !w_pad_slot;
  assign w_lfsr_next   = WIDTH'(lfsr_next(32'(w_lfsr_q), 32'(POLY), WIDTH));

  bist_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .INIT  (SEED_EFF)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_start),
    .load_val (w_seed_use),
    .step     (w_lfsr_step),
    .q        (w_lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_seed  <= SEED_EFF;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (seed_load && w_idle) begin
        r_seed <= w_seed_in_fix;
      end
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state <= RUN;
            r_valid <= 1'b1;
            r_data  <= PAD_EN ? '0 : w_seed_use;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              // pat_data keeps the final vector while in DONE.
              r_state <= DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_index <= r_index + 1'b1;
              r_data  <= w_pad_slot ? w_lfsr_q : w_lfsr_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pat_valid = r_valid;
  assign pat_data  = r_data;
  assign pat_index = r_index;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
